// File: rtl/cp0_regfile_if.sv
// Write-back to CP0 commit bus: committed exception/ERET/MTC0 info in,
// MFC0 data, flush/redirect and interrupt indication out.
interface cp0_regfile_if;
  logic        wb_valid;
  logic        wb_excp;
  logic [4:0]  wb_excode;
  logic        wb_bd;
  logic [31:0] wb_pc;
  logic [31:0] wb_badvaddr;
  logic        wb_eret;
  logic        wb_mtc0;
  logic [7:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic        excp_flush;
  logic        eret_flush;
  logic [31:0] flush_target;
  logic        int_pending;

  modport master (
    output wb_valid, wb_excp, wb_excode, wb_bd, wb_pc, wb_badvaddr,
           wb_eret, wb_mtc0, cp0_addr, cp0_wdata,
    input  cp0_rdata, excp_flush, eret_flush, flush_target, int_pending
  );

  modport slave (
    input  wb_valid, wb_excp, wb_excode, wb_bd, wb_pc, wb_badvaddr,
           wb_eret, wb_mtc0, cp0_addr, cp0_wdata,
    output cp0_rdata, excp_flush, eret_flush, flush_target, int_pending
  );
endinterface

// File: rtl/cp0_regfile.sv
// CP0 register file and exception commit unit: BadVAddr, Count, Compare,
// Status, Cause, EPC plus the Count/Compare timer interrupt.
module cp0_regfile #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] ext_int,
  cp0_regfile_if.slave bus
);

  localparam logic [7:0] ADDR_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] ADDR_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] ADDR_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] ADDR_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] ADDR_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] ADDR_EPC      = {5'd14, 3'd0};

  // Status fields
  logic [7:0]  status_im;
  logic        status_exl;
  logic        status_ie;
  // Cause fields
  logic        cause_bd;
  logic        cause_ti;
  logic [5:0]  ext_q;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  // Full-width registers
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic [31:0] count;
  logic [31:0] compare;
  logic        tick;

  logic        commit_excp;
  logic        commit_eret;
  logic        commit_mtc0;
  logic        wr_status;
  logic        wr_cause;
  logic        wr_epc;
  logic        wr_count;
  logic        wr_compare;
  logic        addr_excp;
  logic [5:0]  cause_ip_hw;
  logic [31:0] status_val;
  logic [31:0] cause_val;

  assign commit_excp = bus.wb_valid & bus.wb_excp;
  assign commit_eret = bus.wb_valid & bus.wb_eret & ~bus.wb_excp;
  assign commit_mtc0 = bus.wb_valid & bus.wb_mtc0 & ~bus.wb_excp;

  assign wr_status  = commit_mtc0 && (bus.cp0_addr == ADDR_STATUS);
  assign wr_cause   = commit_mtc0 && (bus.cp0_addr == ADDR_CAUSE);
  assign wr_epc     = commit_mtc0 && (bus.cp0_addr == ADDR_EPC);
  assign wr_count   = commit_mtc0 && (bus.cp0_addr == ADDR_COUNT);
  assign wr_compare = commit_mtc0 && (bus.cp0_addr == ADDR_COMPARE);

  // Only address-error exceptions (AdEL/AdES) capture the faulting address.
  assign addr_excp = commit_excp &&
                     ((bus.wb_excode == 5'h04) || (bus.wb_excode == 5'h05));

  // TI feeds IP7 directly so the timer interrupt follows TI without extra lag.
  assign cause_ip_hw = {ext_q[5] | cause_ti, ext_q[4:0]};

  assign status_val = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_val  = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                       1'b0, cause_exccode, 2'b00};

  // Exception commit beats ERET beats MTC0 for the EXL bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      status_im  <= 8'd0;
      status_exl <= 1'b0;
      status_ie  <= 1'b0;
    end else begin
      if (wr_status) begin
        status_im <= bus.cp0_wdata[15:8];
        status_ie <= bus.cp0_wdata[0];
      end
      if (commit_excp)
        status_exl <= 1'b1;
      else if (commit_eret)
        status_exl <= 1'b0;
      else if (wr_status)
        status_exl <= bus.cp0_wdata[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cause_bd      <= 1'b0;
      cause_ti      <= 1'b0;
      ext_q         <= 6'd0;
      cause_ip_sw   <= 2'b00;
      cause_exccode <= 5'd0;
    end else begin
      ext_q <= ext_int;
      if (wr_cause)
        cause_ip_sw <= bus.cp0_wdata[9:8];
      if (commit_excp) begin
        cause_exccode <= bus.wb_excode;
        if (!status_exl)
          cause_bd <= bus.wb_bd;
      end
      if (wr_compare)
        cause_ti <= 1'b0;
      else if (count == compare)
        cause_ti <= 1'b1;
    end
  end

  // A nested exception (EXL already set) keeps the original return address.
  always_ff @(posedge clk) begin
    if (reset) begin
      epc      <= 32'd0;
      badvaddr <= 32'd0;
    end else begin
      if (commit_excp) begin
        if (!status_exl)
          epc <= bus.wb_bd ? (bus.wb_pc - 32'd4) : bus.wb_pc;
      end else if (wr_epc) begin
        epc <= bus.cp0_wdata;
      end
      if (addr_excp)
        badvaddr <= bus.wb_badvaddr;
    end
  end

  // Count advances on every other cycle; an MTC0 load wins over the increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick    <= 1'b0;
      count   <= 32'd0;
      compare <= 32'd0;
    end else begin
      tick <= ~tick;
      if (wr_count)
        count <= bus.cp0_wdata;
      else if (tick)
        count <= count + 32'd1;
      if (wr_compare)
        compare <= bus.cp0_wdata;
    end
  end

  always_comb begin
    bus.cp0_rdata = 32'd0;
    case (bus.cp0_addr)
      ADDR_STATUS:   bus.cp0_rdata = status_val;
      ADDR_CAUSE:    bus.cp0_rdata = cause_val;
      ADDR_EPC:      bus.cp0_rdata = epc;
      ADDR_BADVADDR: bus.cp0_rdata = badvaddr;
      ADDR_COUNT:    bus.cp0_rdata = count;
      ADDR_COMPARE:  bus.cp0_rdata = compare;
      default:       bus.cp0_rdata = 32'd0;
    endcase
  end

  // The target only matters while a flush is asserted; it rests at the
  // exception vector otherwise and switches to EPC solely for ERET.
  assign bus.excp_flush   = commit_excp;
  assign bus.eret_flush   = commit_eret;
  assign bus.flush_target = commit_eret ? epc : EXC_VECTOR;

  assign bus.int_pending = status_ie & ~status_exl &
                           (|({cause_ip_hw, cause_ip_sw} & status_im));

endmodule
